reg4_share_arbiter: RTL

//   Round-robin write arbiter that shares one reg4 storage register between
//   NUM_REQ requesters. Samples req lines, picks one winner, and drives the

---
 rtl/reg4_share_arbiter_if.sv | 22 ++
 rtl/reg4_share_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/reg4_share_arbiter_if.sv
// reg4_share_arbiter_if: request/grant bus between requesters, the arbiter and the shared reg4
//   req      requester i wants a write (bit i)
//   req_data data of requester i in slice [i*DATA_W +: DATA_W]
//   gnt      one-hot grant pulse
//   reg_d    data to reg4 D
//   reg_en   write enable to reg4 EN
//   reg_q    reg4 Q readback
//   wr_err   sticky readback mismatch flag
interface reg4_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         reg_d;
  logic                      reg_en;
  logic [DATA_W-1:0]         reg_q;
  logic                      wr_err;
  modport master (output req, req_data, reg_q, input gnt, reg_d, reg_en, wr_err);
  modport slave  (input req, req_data, reg_q, output gnt, reg_d, reg_en, wr_err);
endinterface

// File: rtl/reg4_share_arbiter.sv
// reg4_share_arbiter: round-robin write arbiter sharing one reg4 register between NUM_REQ requesters
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    reg4_share_arbiter_if slave: req/req_data in, gnt/reg_d/reg_en out,
//          reg_q readback in, wr_err out
//   Define REG4_ARB_VERIFY_EN to compare reg_q against the written data in the
//   cycle after each write; otherwise wr_err is tied low and reg_q is ignored.
module reg4_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 4,
  parameter int COOLDOWN = 0
) (
  input logic                 clk,
  input logic                 reset,
  reg4_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, WRITE, COOL} state_t;
  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [3:0]    cnt;
  // scan from the highest offset down so the last hit is the nearest to rr_ptr
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) win = PW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      bus.gnt    <= '0;
      bus.reg_en <= 1'b0;
      bus.reg_d  <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          bus.gnt    <= NUM_REQ'(1) << win;
          bus.reg_en <= 1'b1;
          bus.reg_d  <= bus.req_data[int'(win)*DATA_W +: DATA_W];
          rr_ptr     <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          bus.gnt    <= '0;
          bus.reg_en <= 1'b0;
          cnt        <= 4'(COOLDOWN - 1);
          state      <= (COOLDOWN > 0) ? COOL : IDLE;
        end
        COOL: begin
          cnt   <= cnt - 1'b1;
          state <= (cnt == '0) ? IDLE : COOL;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef REG4_ARB_VERIFY_EN
  // reg_d holds the written value until the next grant, so it serves as the latch
  logic chk;
  always_ff @(posedge clk) begin
    if (reset) begin
      chk        <= 1'b0;
      bus.wr_err <= 1'b0;
    end else begin
      chk <= (state == WRITE);
      if (chk && bus.reg_q != bus.reg_d) bus.wr_err <= 1'b1;
    end
  end
`else
  logic unused_q;
  assign unused_q   = ^bus.reg_q;
  assign bus.wr_err = 1'b0;
`endif
endmodule
